// File: rtl/fetch_buffer.sv
// Instruction queue between the imem response port and decode, with request credits and
// redirect flush. Optional zero-latency bypass when FETCH_BUFFER_BYPASS_EN is defined.
module fetch_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    rsp_valid,
    input  logic [31:0]             rsp_pc,
    input  logic [31:0]             rsp_instr,
    output logic                    deq_valid,
    output logic [31:0]             deq_pc,
    output logic [31:0]             deq_instr,
    input  logic                    deq_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];

    logic          head_valid;
    logic          pop;
    logic          push;
    logic          bypass;
    logic          bypass_take;
    logic [SW-1:0] occupancy;

    assign head_valid = (count_q != '0) & ~flush;
    assign pop        = head_valid & deq_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = (count_q == '0) & (drop_q == '0) & rsp_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif
    assign bypass_take = bypass & deq_ready;

    // A bypassed response that decode takes immediately never occupies a slot.
    assign push = rsp_valid & ~flush & (drop_q == '0) & ~bypass_take;

    // Queued entries plus responses still owed can never exceed the storage.
    assign occupancy = SW'(count_q) + SW'(out_q);
    assign req_ready = (occupancy < SW'(DEPTH)) & (out_q < OW'(MAX_OUT));

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        out_d   = out_q + OW'(req_valid) - OW'(rsp_valid);

        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            // Responses still owed to the old stream; a same-cycle req belongs to the new one.
            drop_d  = (out_q != '0) ? out_q - OW'(rsp_valid) : '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            pc_q[wptr_q]    <= rsp_pc;
            instr_q[wptr_q] <= rsp_instr;
        end
    end

`ifdef FETCH_BUFFER_BYPASS_EN
    always_comb begin
        deq_valid = head_valid | bypass;
        deq_pc    = '0;
        deq_instr = '0;
        if (bypass) begin
            deq_pc    = rsp_pc;
            deq_instr = rsp_instr;
        end else if (head_valid) begin
            deq_pc    = pc_q[rptr_q];
            deq_instr = instr_q[rptr_q];
        end
    end
`else
    always_comb begin
        deq_valid = head_valid;
        deq_pc    = '0;
        deq_instr = '0;
        if (head_valid) begin
            deq_pc    = pc_q[rptr_q];
            deq_instr = instr_q[rptr_q];
        end
    end
`endif

    assign count = count_q;

`ifndef SYNTHESIS
    req_credit_a: assert property (@(posedge clock) disable iff (!reset)
        req_valid |-> req_ready)
        else $error("fetch_buffer: req_valid issued without credit");

    rsp_owed_a: assert property (@(posedge clock) disable iff (!reset)
        rsp_valid |-> (out_q != '0))
        else $error("fetch_buffer: rsp_valid with no request outstanding");

    occupancy_a: assert property (@(posedge clock) disable iff (!reset)
        occupancy <= SW'(DEPTH))
        else $error("fetch_buffer: queued plus outstanding exceeds depth");

    drop_bound_a: assert property (@(posedge clock) disable iff (!reset)
        drop_q <= out_q)
        else $error("fetch_buffer: more drops pending than requests outstanding");
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer (base build, DEPTH=4). A second instance with
// MAX_OUT=3 covers a flush that also carries a request and a response.
module tb_fetch_buffer;

    logic        clock = 1'b0;
    logic        reset;

    logic        a_flush, a_req_valid, a_req_ready, a_rsp_valid, a_deq_valid, a_deq_ready;
    logic [31:0] a_rsp_pc, a_rsp_instr, a_deq_pc, a_deq_instr;
    logic [2:0]  a_count;

    logic        b_flush, b_req_valid, b_req_ready, b_rsp_valid, b_deq_valid, b_deq_ready;
    logic [31:0] b_rsp_pc, b_rsp_instr, b_deq_pc, b_deq_instr;
    logic [2:0]  b_count;

    always #5 clock = ~clock;

    fetch_buffer #(.DEPTH(4), .MAX_OUT(2)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .flush     (a_flush),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_pc    (a_rsp_pc),
        .rsp_instr (a_rsp_instr),
        .deq_valid (a_deq_valid),
        .deq_pc    (a_deq_pc),
        .deq_instr (a_deq_instr),
        .deq_ready (a_deq_ready),
        .count     (a_count)
    );

    fetch_buffer #(.DEPTH(4), .MAX_OUT(3)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .flush     (b_flush),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_pc    (b_rsp_pc),
        .rsp_instr (b_rsp_instr),
        .deq_valid (b_deq_valid),
        .deq_pc    (b_deq_pc),
        .deq_instr (b_deq_instr),
        .deq_ready (b_deq_ready),
        .count     (b_count)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        req;
        logic        rsp;
        logic [31:0] pc;
        logic        dr;
        logic        exp_dv;
        logic [31:0] exp_pc;
        logic        exp_rr;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    function automatic vec_t v(input logic fl, input logic rq, input logic rs,
                               input logic [31:0] pc, input logic dr, input logic edv,
                               input logic [31:0] epc, input logic err, input int ecnt);
        vec_t t;
        t.rst     = 1'b1;
        t.flush   = fl;
        t.req     = rq;
        t.rsp     = rs;
        t.pc      = pc;
        t.dr      = dr;
        t.exp_dv  = edv;
        t.exp_pc  = epc;
        t.exp_rr  = err;
        t.exp_cnt = 3'(ecnt);
        return t;
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input bit on_b, input vec_t t, input string tag, input int idx);
        logic        dv, rr;
        logic [31:0] pc, instr;
        logic [2:0]  cnt;
        bit          ok;
        @(negedge clock);
        reset = t.rst;
        if (on_b) begin
            b_flush = t.flush; b_req_valid = t.req; b_rsp_valid = t.rsp;
            b_rsp_pc = t.pc; b_rsp_instr = instr_of(t.pc); b_deq_ready = t.dr;
        end else begin
            a_flush = t.flush; a_req_valid = t.req; a_rsp_valid = t.rsp;
            a_rsp_pc = t.pc; a_rsp_instr = instr_of(t.pc); a_deq_ready = t.dr;
        end
        #1;
        dv    = on_b ? b_deq_valid : a_deq_valid;
        rr    = on_b ? b_req_ready : a_req_ready;
        pc    = on_b ? b_deq_pc    : a_deq_pc;
        instr = on_b ? b_deq_instr : a_deq_instr;
        cnt   = on_b ? b_count     : a_count;
        ok = (dv == t.exp_dv) && (rr == t.exp_rr) && (cnt == t.exp_cnt);
        if (t.exp_dv && ((pc != t.exp_pc) || (instr != instr_of(t.exp_pc)))) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s[%0d]: got dv=%b pc=%h instr=%h rr=%b cnt=%0d; want dv=%b pc=%h instr=%h rr=%b cnt=%0d",
                     tag, idx, dv, pc, instr, rr, cnt,
                     t.exp_dv, t.exp_pc, instr_of(t.exp_pc), t.exp_rr, t.exp_cnt);
        end
    endtask

    task automatic check_reset(input string tag, input logic dv, input logic [31:0] pc,
                               input logic [31:0] instr, input logic rr, input logic [2:0] cnt);
        n_vec++;
        if (dv !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || rr !== 1'b1 || cnt !== 3'd0) begin
            n_err++;
            $display("FAIL %s: got dv=%b pc=%h instr=%h rr=%b cnt=%0d; want dv=0 pc=0 instr=0 rr=1 cnt=0",
                     tag, dv, pc, instr, rr, cnt);
        end
    endtask

    initial begin
        vec_t t;
        vec_t b_seq[$];

        // Stream of four: each response visible one cycle later, in order.
        vecs.push_back(v(0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h0,   1, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h4,   1, 1, 32'h0,   1, 1));
        vecs.push_back(v(0, 1, 1, 32'h8,   1, 1, 32'h4,   1, 1));
        vecs.push_back(v(0, 0, 1, 32'hC,   1, 1, 32'h8,   1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'hC,   1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0));
        // Fill to four with decode stalled, credits close, one pop reopens, six drain with wrap.
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 0, 1, 32'h100, 0, 0, 32'h0,   0, 0));
        vecs.push_back(v(0, 1, 1, 32'h104, 0, 1, 32'h100, 1, 1));
        vecs.push_back(v(0, 1, 1, 32'h108, 0, 1, 32'h100, 1, 2));
        vecs.push_back(v(0, 0, 1, 32'h10C, 0, 1, 32'h100, 0, 3));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h100, 0, 4));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h100, 0, 4));
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 1, 32'h104, 1, 3));
        vecs.push_back(v(0, 0, 1, 32'h110, 0, 1, 32'h104, 0, 3));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h104, 0, 4));
        vecs.push_back(v(0, 1, 0, 32'h0,   1, 1, 32'h108, 1, 3));
        vecs.push_back(v(0, 0, 1, 32'h114, 1, 1, 32'h10C, 1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h110, 1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h114, 1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        // Flush with two queued and two owed; the owed pair is dropped, redirect fetch lands.
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h200, 0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h204, 0, 1, 32'h200, 1, 1));
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 1, 32'h200, 1, 2));
        vecs.push_back(v(1, 0, 0, 32'h0,   1, 0, 32'h0,   0, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0));
        vecs.push_back(v(0, 0, 1, 32'h10,  0, 0, 32'h0,   0, 0));
        vecs.push_back(v(0, 1, 1, 32'h14,  0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 0, 1, 32'h80,  1, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h80,  1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        // count+out_cnt never exceeds DEPTH, so sustained push+pop+req runs at count=2.
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h400, 0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h404, 0, 1, 32'h400, 1, 1));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(v(0, 1, 1, 32'h408 + 32'(4 * i), 1, 1, 32'h400 + 32'(4 * i), 1, 2));
        end
        vecs.push_back(v(0, 0, 1, 32'h428, 1, 1, 32'h420, 1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h424, 1, 2));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h428, 1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        // Reset mid-stream discards the queued entry; later traffic starts fresh.
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 1, 1, 32'h500, 0, 0, 32'h0,   1, 0));
        t = v(0, 0, 0, 32'h0, 0, 1, 32'h500, 1, 1);
        t.rst = 1'b0;
        vecs.push_back(t);
        vecs.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 0, 1, 32'h504, 0, 0, 32'h0,   1, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h504, 1, 1));
        vecs.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0));

        a_flush = 0; a_req_valid = 0; a_deq_ready = 0; a_rsp_pc = 32'h55;
        a_rsp_instr = instr_of(32'h55);
        b_flush = 0; b_req_valid = 0; b_deq_ready = 0; b_rsp_pc = 32'h55;
        b_rsp_instr = instr_of(32'h55);

        // Reset held two cycles while imem drives a response.
        reset = 1'b0; a_rsp_valid = 1'b1; b_rsp_valid = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1; a_rsp_valid = 1'b0; b_rsp_valid = 1'b0;
        #1;
        check_reset("reset_a", a_deq_valid, a_deq_pc, a_deq_instr, a_req_ready, a_count);
        check_reset("reset_b", b_deq_valid, b_deq_pc, b_deq_instr, b_req_ready, b_count);

        foreach (vecs[i]) apply(1'b0, vecs[i], "vec", i);

        // Flush carrying a response and a new request with two owed: exactly one is dropped.
        b_seq.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        b_seq.push_back(v(0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        b_seq.push_back(v(1, 1, 1, 32'h300, 0, 0, 32'h0,   1, 0));
        b_seq.push_back(v(0, 0, 1, 32'h304, 0, 0, 32'h0,   1, 0));
        b_seq.push_back(v(0, 0, 1, 32'h380, 1, 0, 32'h0,   1, 0));
        b_seq.push_back(v(0, 0, 0, 32'h0,   1, 1, 32'h380, 1, 1));
        b_seq.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0));
        foreach (b_seq[i]) apply(1'b1, b_seq[i], "flush_rsp_req", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
